// File: rtl/weight_fill_sequencer.sv
// Weight-tile fill sequencer: walks a rows x tiles address space into the per-column
// weight memories and forwards the read strobes to the systolic-array weight FIFOs.
module weight_fill_sequencer #(
  parameter int unsigned SYS_ARR_ROWS = 16,
  parameter int unsigned SYS_ARR_COLS = 16,
  parameter int unsigned ADDR_WIDTH   = 8,
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned TILE_WIDTH   = 4
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               start,
  input  logic                               abort,
  input  logic [$clog2(SYS_ARR_ROWS)-1:0]    num_row,
  input  logic [$clog2(SYS_ARR_COLS)-1:0]    num_col,
  input  logic [TILE_WIDTH-1:0]              num_tiles,
  input  logic [ADDR_WIDTH-1:0]              base_addr,
  input  logic [ADDR_WIDTH-1:0]              tile_stride,
  input  logic                               fifo_ready,
  output logic                               busy,
  output logic                               done,
  output logic [SYS_ARR_COLS-1:0]            weightMem_rd_en,
  output logic [SYS_ARR_COLS*ADDR_WIDTH-1:0] weightMem_rd_addr,
  output logic [SYS_ARR_COLS-1:0]            fifo_wr_en,
  output logic                               fifo_active,
  output logic [TILE_WIDTH-1:0]              tile_idx
);

  localparam int unsigned ROW_W = $clog2(SYS_ARR_ROWS);
  localparam int unsigned COL_W = $clog2(SYS_ARR_COLS);
  localparam int unsigned LAT   = READ_LATENCY;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  state_e                           state_q, state_d;
  logic [ROW_W-1:0]                 row_q, row_d;
  logic [TILE_WIDTH-1:0]            tile_q, tile_d;
  logic [ROW_W-1:0]                 num_row_q, num_row_d;
  logic [COL_W-1:0]                 num_col_q, num_col_d;
  logic [TILE_WIDTH-1:0]            num_tiles_q, num_tiles_d;
  logic [ADDR_WIDTH-1:0]            stride_q, stride_d;
  logic [ADDR_WIDTH-1:0]            tile_base_q, tile_base_d;
  logic [LAT-1:0][SYS_ARR_COLS-1:0] wr_pipe_q, wr_pipe_d;
  logic [LAT-1:0]                   act_pipe_q, act_pipe_d;
  logic [LAT-1:0]                   last_pipe_q, last_pipe_d;

  logic                             issue_c;
  logic                             row_last_c;
  logic                             tile_last_c;
  logic [SYS_ARR_COLS-1:0]          col_mask_c;
  logic [SYS_ARR_COLS-1:0]          rd_en_c;
  logic [ADDR_WIDTH-1:0]            rd_addr_c;

  // Thermometer mask of the active columns.
  always_comb begin
    col_mask_c = '0;
    for (int i = 0; i < int'(SYS_ARR_COLS); i++) begin
      col_mask_c[i] = (COL_W'(i) <= num_col_q);
    end
  end

  assign issue_c     = (state_q == S_ISSUE) && fifo_ready && !abort;
  assign row_last_c  = (row_q == num_row_q);
  assign tile_last_c = (tile_q == num_tiles_q);
  assign rd_en_c     = issue_c ? col_mask_c : '0;
  assign rd_addr_c   = tile_base_q + ADDR_WIDTH'(row_q);

  // Next-state, counter and delay-pipeline logic.
  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    tile_d      = tile_q;
    num_row_d   = num_row_q;
    num_col_d   = num_col_q;
    num_tiles_d = num_tiles_q;
    stride_d    = stride_q;
    tile_base_d = tile_base_q;
    wr_pipe_d   = wr_pipe_q;
    act_pipe_d  = act_pipe_q;
    last_pipe_d = last_pipe_q;

    wr_pipe_d[0]   = rd_en_c;
    act_pipe_d[0]  = issue_c && (row_q == '0);
    last_pipe_d[0] = issue_c && row_last_c && tile_last_c;
    for (int i = 1; i < int'(LAT); i++) begin
      wr_pipe_d[i]   = wr_pipe_q[i-1];
      act_pipe_d[i]  = act_pipe_q[i-1];
      last_pipe_d[i] = last_pipe_q[i-1];
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d     = S_ISSUE;
          row_d       = '0;
          tile_d      = '0;
          num_row_d   = num_row;
          num_col_d   = num_col;
          num_tiles_d = num_tiles;
          stride_d    = tile_stride;
          tile_base_d = base_addr;
        end
      end
      S_ISSUE: begin
        if (issue_c) begin
          if (row_last_c) begin
            row_d = '0;
            if (tile_last_c) begin
              state_d = S_DRAIN;
            end else begin
              tile_d      = tile_q + TILE_WIDTH'(1);
              tile_base_d = tile_base_q + stride_q;
            end
          end else begin
            row_d = row_q + ROW_W'(1);
          end
        end
      end
      S_DRAIN: begin
        // The final row's data leaves the delay line this cycle.
        if (last_pipe_q[LAT-1]) begin
          state_d = S_IDLE;
          tile_d  = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (abort) begin
      state_d     = S_IDLE;
      row_d       = '0;
      tile_d      = '0;
      wr_pipe_d   = '0;
      act_pipe_d  = '0;
      last_pipe_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      row_q       <= '0;
      tile_q      <= '0;
      num_row_q   <= '0;
      num_col_q   <= '0;
      num_tiles_q <= '0;
      stride_q    <= '0;
      tile_base_q <= '0;
      wr_pipe_q   <= '0;
      act_pipe_q  <= '0;
      last_pipe_q <= '0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      tile_q      <= tile_d;
      num_row_q   <= num_row_d;
      num_col_q   <= num_col_d;
      num_tiles_q <= num_tiles_d;
      stride_q    <= stride_d;
      tile_base_q <= tile_base_d;
      wr_pipe_q   <= wr_pipe_d;
      act_pipe_q  <= act_pipe_d;
      last_pipe_q <= last_pipe_d;
    end
  end

  assign busy              = (state_q != S_IDLE);
  assign done              = last_pipe_q[LAT-1];
  assign weightMem_rd_en   = rd_en_c;
  assign weightMem_rd_addr = issue_c ? {SYS_ARR_COLS{rd_addr_c}} : '0;
  assign fifo_wr_en        = wr_pipe_q[LAT-1];
  assign fifo_active       = act_pipe_q[LAT-1];
  assign tile_idx          = tile_q;

endmodule

// File: tb/tb_weight_fill_sequencer.sv
// Bench for weight_fill_sequencer: two instances (read latency 1 and 3) share stimulus
// and are compared each cycle against an address-list / delay-history reference model.
module tb_weight_fill_sequencer;

  localparam int MAXC = 2000;
  localparam int BIG  = 1 << 20;

  logic         clk = 1'b0;
  logic         reset, start, abort, fifo_ready;
  logic [3:0]   num_row, num_col, num_tiles;
  logic [7:0]   base_addr, tile_stride;

  logic         busy1, done1, act1, busy3, done3, act3;
  logic [15:0]  rd1, wr1, rd3, wr3;
  logic [127:0] addr1, addr3;
  logic [3:0]   tile1, tile3;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  weight_fill_sequencer #(.READ_LATENCY(1)) dut1 (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .num_row(num_row), .num_col(num_col), .num_tiles(num_tiles),
    .base_addr(base_addr), .tile_stride(tile_stride), .fifo_ready(fifo_ready),
    .busy(busy1), .done(done1), .weightMem_rd_en(rd1), .weightMem_rd_addr(addr1),
    .fifo_wr_en(wr1), .fifo_active(act1), .tile_idx(tile1)
  );

  weight_fill_sequencer #(.READ_LATENCY(3)) dut3 (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .num_row(num_row), .num_col(num_col), .num_tiles(num_tiles),
    .base_addr(base_addr), .tile_stride(tile_stride), .fifo_ready(fifo_ready),
    .busy(busy3), .done(done3), .weightMem_rd_en(rd3), .weightMem_rd_addr(addr3),
    .fifo_wr_en(wr3), .fifo_active(act3), .tile_idx(tile3)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, " busy1"}, 128'(busy1), 128'(0));
    check({tag, " done1"}, 128'(done1), 128'(0));
    check({tag, " act1"},  128'(act1),  128'(0));
    check({tag, " rd1"},   128'(rd1),   128'(0));
    check({tag, " wr1"},   128'(wr1),   128'(0));
    check({tag, " addr1"}, addr1,       128'(0));
    check({tag, " tile1"}, 128'(tile1), 128'(0));
    check({tag, " busy3"}, 128'(busy3), 128'(0));
    check({tag, " done3"}, 128'(done3), 128'(0));
    check({tag, " act3"},  128'(act3),  128'(0));
    check({tag, " rd3"},   128'(rd3),   128'(0));
    check({tag, " wr3"},   128'(wr3),   128'(0));
    check({tag, " addr3"}, addr3,       128'(0));
    check({tag, " tile3"}, 128'(tile3), 128'(0));
  endtask

  // One fill. rmode: 0 always ready, 1 stall window [s0,s1), 2 random. ab: abort cycle or -1.
  task automatic run_fill(input string nm, input int nr, input int nc, input int nt,
                          input logic [7:0] base, input logic [7:0] stride,
                          input int rmode, input int s0, input int s1, input int ab);
    logic [15:0] e_rd [MAXC];
    bit          e_first [MAXC];
    logic [15:0] mask;
    logic [7:0]  ea;
    int          k, last, a, total, rows, et;
    bit          iss, ended;
    rows  = nr + 1;
    total = rows * (nt + 1);
    mask  = 16'((32'd1 << (nc + 1)) - 32'd1);
    k     = 0;
    last  = BIG;
    a     = BIG;
    ended = 1'b0;
    for (int n = 0; n < MAXC; n++) begin
      @(negedge clk);
      if (n == 0) begin
        start       = 1'b1;
        abort       = (ab == 0);
        num_row     = 4'(nr);
        num_col     = 4'(nc);
        num_tiles   = 4'(nt);
        base_addr   = base;
        tile_stride = stride;
        fifo_ready  = 1'b1;
        if (ab == 0) a = 0;
      end else begin
        abort = (n == ab) && (k < total);
        if (abort) a = n;
        start       = (n < a) && (k < total) && ($urandom_range(0, 7) == 0);
        num_row     = 4'($urandom);
        num_col     = 4'($urandom);
        num_tiles   = 4'($urandom);
        base_addr   = 8'($urandom);
        tile_stride = 8'($urandom);
        case (rmode)
          0:       fifo_ready = 1'b1;
          1:       fifo_ready = !(n >= s0 && n < s1);
          default: fifo_ready = ($urandom_range(0, 9) < 7);
        endcase
      end
      iss        = (n >= 1) && (n < a) && (k < total) && fifo_ready;
      e_rd[n]    = iss ? mask : 16'h0;
      e_first[n] = iss && (k % rows == 0);
      et         = k / rows;
      ea         = 8'(int'(base) + et * int'(stride) + (k % rows));
      #1;
      check($sformatf("%s rd1 n=%0d", nm, n), 128'(rd1), 128'(e_rd[n]));
      check($sformatf("%s rd3 n=%0d", nm, n), 128'(rd3), 128'(e_rd[n]));
      if (iss) begin
        check($sformatf("%s addr1 n=%0d", nm, n), addr1, {16{ea}});
        check($sformatf("%s addr3 n=%0d", nm, n), addr3, {16{ea}});
        check($sformatf("%s tile1 n=%0d", nm, n), 128'(tile1), 128'(et));
        check($sformatf("%s tile3 n=%0d", nm, n), 128'(tile3), 128'(et));
      end
      for (int j = 0; j < 2; j++) begin
        int          lat;
        logic [15:0] ewr, gwr;
        logic        eact, edone, ebusy, gact, gdone, gbusy;
        lat   = (j == 0) ? 1 : 3;
        ewr   = (n <= a && n - lat >= 0) ? e_rd[n - lat] : 16'h0;
        eact  = (n <= a && n - lat >= 0) ? e_first[n - lat] : 1'b0;
        edone = (n == last + lat) && (n <= a);
        ebusy = (n >= 1) && (n <= a) && (n <= last + lat);
        gwr   = (j == 0) ? wr1 : wr3;
        gact  = (j == 0) ? act1 : act3;
        gdone = (j == 0) ? done1 : done3;
        gbusy = (j == 0) ? busy1 : busy3;
        check($sformatf("%s wr L%0d n=%0d", nm, lat, n),   128'(gwr),   128'(ewr));
        check($sformatf("%s act L%0d n=%0d", nm, lat, n),  128'(gact),  128'(eact));
        check($sformatf("%s done L%0d n=%0d", nm, lat, n), 128'(gdone), 128'(edone));
        check($sformatf("%s busy L%0d n=%0d", nm, lat, n), 128'(gbusy), 128'(ebusy));
      end
      if (iss) begin
        k++;
        if (k == total) last = n;
      end
      if ((a < BIG && n >= a + 2) || (last < BIG && n >= last + 5)) begin
        ended = 1'b1;
        break;
      end
    end
    if (!ended) check({nm, " cycle budget"}, 128'(0), 128'(1));
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; abort = 1'b0; fifo_ready = 1'b0;
    num_row = '0; num_col = '0; num_tiles = '0; base_addr = '0; tile_stride = '0;
    repeat (2) @(negedge clk);
    #1;
    check_zero("reset_vals");
    @(negedge clk);
    reset = 1'b1;

    run_fill("full_tile", 15, 15, 0, 8'h10, 8'h00, 0, 0, 0, -1);
    run_fill("partial",    3,  5, 0, 8'h42, 8'h00, 0, 0, 0, -1);
    run_fill("wrap3",      1,  7, 2, 8'hF8, 8'h20, 0, 0, 0, -1);
    run_fill("stall",      7, 10, 0, 8'h30, 8'h00, 1, 4, 9, -1);
    run_fill("stall_xt",   2, 15, 2, 8'h05, 8'h11, 1, 3, 8, -1);
    run_fill("abort_r2",   5,  9, 1, 8'h60, 8'h08, 0, 0, 0, 3);
    run_fill("restart",    5,  9, 1, 8'h60, 8'h08, 0, 0, 0, -1);
    run_fill("start_abort",4,  4, 0, 8'h70, 8'h00, 0, 0, 0, 0);

    // Asynchronous reset in the middle of issuing.
    @(negedge clk);
    start = 1'b1; abort = 1'b0; fifo_ready = 1'b1;
    num_row = 4'd7; num_col = 4'd3; num_tiles = 4'd1; base_addr = 8'h20; tile_stride = 8'h10;
    repeat (3) begin
      @(negedge clk);
      start = 1'b0;
    end
    #1;
    check("pre_reset busy1", 128'(busy1), 128'(1));
    check("pre_reset rd3", 128'(rd3), 128'(16'h000F));
    #1;
    reset = 1'b0;
    #1;
    check_zero("async_reset");
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    #1;
    check_zero("post_reset");

    for (int r = 0; r < 25; r++) begin
      int ab;
      ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 12)) : -1;
      run_fill($sformatf("rand%0d", r), int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
               int'($urandom_range(0, 3)), 8'($urandom), 8'($urandom), 2, 0, 0, ab);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
